// File: rtl/req_arbiter_4to1_fsm.sv
// -----------------------------------------------------------------------------
// req_arbiter_4to1_fsm
//
// Purpose:
//   Clocked 4-requester arbiter in front of a shared datapath. The winner is
//   resolved like the 4-to-2 priority encoder (req[3] highest, req[0] lowest).
//   It is then registered and held by an IDLE/BUSY/GAP state machine. An owner
//   keeps the grant until it drops its request or until it has held the grant
//   for MAX_HOLD consecutive cycles. Every release is followed by exactly one
//   dead GAP cycle.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   4  level-sensitive request lines, bit i = requester i
//   gnt        out  4  registered one-hot grant, zero when there is no owner
//   gnt_idx    out  2  registered binary index of the owner, 0 when idle
//   gnt_valid  out  1  registered, 1 while a grant is held
//   preempt    out  1  one-cycle pulse when MAX_HOLD withdraws the grant
//
// Parameters:
//   MAX_HOLD   maximum consecutive grant cycles per owner (1..15, 0 = unlimited)
//   CNT_W      hold counter width, 2**CNT_W > MAX_HOLD
//
// Optional feature (macro ROUND_ROBIN_EN):
//   When defined, every exit from BUSY sets rr_ptr to owner+1 (mod 4). The
//   next IDLE selection searches circularly from rr_ptr. When undefined, the
//   selection is fixed priority and there is no rotation logic.
// -----------------------------------------------------------------------------
module req_arbiter_4to1_fsm #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // Fixed priority: the highest-numbered asserted request wins.
  function automatic logic [1:0] fixed_winner(input logic [3:0] r);
    logic [1:0] w;
    if (r[3]) begin
      w = 2'd3;
    end else if (r[2]) begin
      w = 2'd2;
    end else if (r[1]) begin
      w = 2'd1;
    end else begin
      w = 2'd0;
    end
    return w;
  endfunction

  function automatic logic [3:0] to_onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

`ifdef ROUND_ROBIN_EN
  // Circular search from ptr. Walking the offsets from far to near and
  // overwriting leaves the nearest asserted index, so ptr itself wins first.
  function automatic logic [1:0] rr_winner(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] w;
    logic [1:0] cand;
    w = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (r[cand]) begin
        w = cand;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction
`endif

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       winner_s;
  logic             limit_hit_s;

`ifdef ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  // Rotation takes effect only after the first release. Until then the
  // selection is fixed priority, so req[3] wins the first round after reset.
  logic       rr_armed_q, rr_armed_d;
`endif

  // Pick the candidate owner for the next IDLE arbitration.
  always_comb begin
`ifdef ROUND_ROBIN_EN
    if (rr_armed_q) begin
      winner_s = rr_winner(req, rr_ptr_q);
    end else begin
      winner_s = fixed_winner(req);
    end
`else
    winner_s = fixed_winner(req);
`endif
  end

  // The hold limit is compared only when it is enabled (MAX_HOLD != 0).
  assign limit_hit_s = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));

  // Next-state and next-output computation for the grant FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
`ifdef ROUND_ROBIN_EN
    rr_ptr_d    = rr_ptr_q;
    rr_armed_d  = rr_armed_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d     = S_BUSY;
          gnt_d       = to_onehot(winner_s);
          gnt_idx_d   = winner_s;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d     = S_IDLE;
          gnt_d       = 4'b0000;
          gnt_idx_d   = 2'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = {CNT_W{1'b0}};
        end
      end
      S_BUSY: begin
        if (!req[gnt_idx_q] || limit_hit_s) begin
          // Release: voluntary drop, or forced withdrawal at the hold limit.
          state_d     = S_GAP;
          gnt_d       = 4'b0000;
          gnt_idx_d   = 2'd0;
          gnt_valid_d = 1'b0;
          preempt_d   = req[gnt_idx_q];
          hold_cnt_d  = {CNT_W{1'b0}};
`ifdef ROUND_ROBIN_EN
          rr_ptr_d    = gnt_idx_q + 2'd1;
          rr_armed_d  = 1'b1;
`endif
        end else begin
          // Grant is stable; hold_cnt is frozen when the limit is disabled
          // and saturates instead of wrapping.
          state_d = S_BUSY;
          if ((MAX_HOLD != 0) && (hold_cnt_q != {CNT_W{1'b1}})) begin
            hold_cnt_d = hold_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
      end
      S_GAP: begin
        state_d     = S_IDLE;
        gnt_d       = 4'b0000;
        gnt_idx_d   = 2'd0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = {CNT_W{1'b0}};
      end
      default: begin
        state_d     = S_IDLE;
        gnt_d       = 4'b0000;
        gnt_idx_d   = 2'd0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= {CNT_W{1'b0}};
`ifdef ROUND_ROBIN_EN
      rr_ptr_q    <= 2'd0;
      rr_armed_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
      rr_armed_q  <= rr_armed_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule
